ex_mem_skid: RTL and testbench
==============================

# ex_mem_skid

Two-entry elastic buffer between the ALU (execute) and the memory/writeback stage. Captures the ALU's `result1`/`result2` pair, destination register and write-enable, resolves the branch condition from the ALU's `eq`/`lesser`/`greater_eq` flags, and presents the entries in order to the downstream stage over a valid/ready handshake. Supports flush on a taken branch or trap.

## Interface
- `DW`, default 32: data width of both result fields.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  execute stage offers an entry.
- `in_ready`  out  1  buffer can accept an entry this cycle.
- `in_result1`  in  DW  ALU `result1`.
- `in_result2`  in  DW  ALU `result2` (high product or remainder).
- `in_eq`, `in_lesser`, `in_greater_eq`  in  1 each  ALU compare flags.
- `in_br_type`  in  3  branch type:
  - 000 none; 001 beq; 010 bne; 011 blt/bltu; 100 bge/bgeu.
  - 101–111 are treated as none.
- `in_rd`  in  5  destination register index.
- `in_wb_en`  in  1  register write enable.
- `flush`  in  1  synchronous discard of all held entries.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  downstream consumes the head.
- `out_result1`, `out_result2`  out  DW  head entry results.
- `out_rd`  out  5  head entry destination register.
- `out_wb_en`  out  1  head entry write enable.
- `out_taken`  out  1  resolved branch outcome of the head entry.
- `count`  out  2  occupancy, 0–2.

## Operation
- **Storage:** two entries plus 1-bit write and read pointers; each pointer wraps 1→0.
- **Handshakes:**
  - push = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
  - `in_ready = (count != 2)`, driven combinationally from the occupancy register only, with no dependence on `out_ready`.
  - `out_valid = (count != 0)`.
- **Taken resolution at push:** `taken` is stored with the entry.
  - beq: `in_eq`.
  - bne: `~in_eq`.
  - blt: `in_lesser`.
  - bge: `in_greater_eq`.
  - Any other type: 0.
- **Occupancy update:**
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; write and read happen in the same cycle and both pointers advance.
  - When full, push cannot occur, so a pop yields count 1.
- **Head outputs:** `out_*` always reflect the entry at the read pointer. When `count == 0` the values are stale and must be ignored.
- **Flush:**
  - Has priority over push and pop in the same cycle.
  - Sets count to 0 and both pointers to 0.
  - Drops any entry offered that cycle.
  - Entry contents are not cleared.
- **Reset:**
  - Asynchronous and may occur mid-operation.
  - Sets count, both pointers and all stored fields to 0.
  - Resulting outputs: `out_valid=0`, `in_ready=1`, `out_result1=0`, `out_result2=0`, `out_rd=0`, `out_wb_en=0`, `out_taken=0`, `count=0`.
- **Unsigned branches:** no special handling. The ALU already selects signed or unsigned compare; this block only consumes the flags.

## Timing
- **Latency:** an entry pushed at edge N is visible on `out_*` with `out_valid=1` immediately after edge N (one cycle).
- **Throughput:** one entry per cycle sustained while `out_ready=1`.
- **Back-pressure:** with `out_ready=0`, two entries are accepted, then `in_ready` drops after the second push edge. `in_ready` rises again in the cycle after the first pop.
- **Data stability:** `out_*` hold steady while `out_valid=1` and `out_ready=0`.
- **Flush timing:** flush at edge N gives `out_valid=0` and `in_ready=1` after edge N. A push one cycle later is accepted normally.
- No combinational path from `in_*` to `out_*`, nor from `out_ready` to `in_ready`.

## Test plan
- **Reset and single pass-through:** reset, then push `result1=0x0000_0005`, `result2=0`, `rd=3`, `wb_en=1` with `out_ready=1` → next cycle `out_valid=1`, `out_result1=5`, `out_rd=3`; the following cycle `count=0`.
- **Fill and drain:** with `out_ready=0`, push A=0x11 then B=0x22 → `count=2`, `in_ready=0`, head=0x11, a third offer is ignored. Raise `out_ready` → 0x11 then 0x22 in order, then `out_valid=0`.
- **Simultaneous push/pop:** at `count=1` with head 0x11, push 0x33 while popping → `count` stays 1 and the head becomes 0x33. Repeat across pointer wrap for 8 cycles; the order must be preserved.
- **Branch resolution:**
  - `br_type=001`, `eq=1` → `out_taken=1`.
  - `br_type=010`, `eq=1` → 0.
  - `br_type=011`, `lesser=1` → 1.
  - `br_type=100`, `greater_eq=0` → 0.
  - `br_type=111`, all flags 1 → 0.
- **Flush priority:** at `count=2`, assert `flush` together with `in_valid=1` and `out_ready=1` → after the edge `count=0` and the offered entry is not stored. The next push of 0x44 appears as head.
- **Reset mid-operation:** assert `rst` asynchronously between edges at `count=2` → all outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_skid_if.sv
// Execute-to-memory handshake bundle: ALU results, compare flags and branch type in, resolved entry out.
interface ex_mem_skid_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result1;
    logic [DW-1:0] in_result2;
    logic          in_eq;
    logic          in_lesser;
    logic          in_greater_eq;
    logic [2:0]    in_br_type;
    logic [4:0]    in_rd;
    logic          in_wb_en;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result1;
    logic [DW-1:0] out_result2;
    logic [4:0]    out_rd;
    logic          out_wb_en;
    logic          out_taken;
    logic [1:0]    count;

    modport master (
        output in_valid, in_result1, in_result2, in_eq, in_lesser, in_greater_eq,
               in_br_type, in_rd, in_wb_en, flush, out_ready,
        input  in_ready, out_valid, out_result1, out_result2, out_rd, out_wb_en,
               out_taken, count
    );

    modport slave (
        input  in_valid, in_result1, in_result2, in_eq, in_lesser, in_greater_eq,
               in_br_type, in_rd, in_wb_en, flush, out_ready,
        output in_ready, out_valid, out_result1, out_result2, out_rd, out_wb_en,
               out_taken, count
    );
endinterface

// File: rtl/ex_mem_skid.sv
// Two-entry EX/MEM elastic buffer with branch resolution at push; one-cycle latency.
// in_ready depends only on occupancy, so out_ready never reaches it combinationally.
module ex_mem_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_skid_if.slave  bus
);
    typedef struct packed {
        logic [DW-1:0] result1;
        logic [DW-1:0] result2;
        logic [4:0]    rd;
        logic          wb_en;
        logic          taken;
    } entry_t;

    entry_t     r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic       w_push;
    logic       w_pop;
    logic       w_taken;
    entry_t     w_in;
    entry_t     w_head;

    assign bus.in_ready  = (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign w_push        = bus.in_valid & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;

    // Signed/unsigned selection already happened in the ALU; only the flags matter here.
    always_comb begin
        w_taken = 1'b0;
        case (bus.in_br_type)
            3'b001:  w_taken = bus.in_eq;
            3'b010:  w_taken = ~bus.in_eq;
            3'b011:  w_taken = bus.in_lesser;
            3'b100:  w_taken = bus.in_greater_eq;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_in         = '0;
        w_in.result1 = bus.in_result1;
        w_in.result2 = bus.in_result2;
        w_in.rd      = bus.in_rd;
        w_in.wb_en   = bus.in_wb_en;
        w_in.taken   = w_taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (bus.flush) begin
            // Stored payloads are left as-is; only the bookkeeping is cleared.
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_in;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head          = r_mem[r_rptr];
    assign bus.out_result1 = w_head.result1;
    assign bus.out_result2 = w_head.result2;
    assign bus.out_rd      = w_head.rd;
    assign bus.out_wb_en   = w_head.wb_en;
    assign bus.out_taken   = w_head.taken;
    assign bus.count       = r_count;
endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: stimulus queues expected entries, a negedge monitor checks pops.
module tb_ex_mem_skid;
    logic clk;
    logic rst;

    ex_mem_skid_if #(.DW(32)) bus ();

    ex_mem_skid #(.DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic        wb;
        logic        tk;
    } exp_t;

    exp_t exp_q [$];
    int   n_pass = 0;
    int   n_total = 0;

    logic [2:0] br_v [9] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b010, 3'b100, 3'b000, 3'b101};
    logic       eq_v [9] = '{1'b1,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
    logic       lt_v [9] = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
    logic       ge_v [9] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1};
    logic       tk_v [9] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one entry for one cycle; queues it as expected output only when it should be accepted.
    task automatic offer(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd,
                         input logic wb, input logic [2:0] br, input logic eq, input logic lt,
                         input logic ge, input logic tk, input logic accept);
        exp_t e;
        bus.in_valid      = 1'b1;
        bus.in_result1    = r1;
        bus.in_result2    = r2;
        bus.in_rd         = rd;
        bus.in_wb_en      = wb;
        bus.in_br_type    = br;
        bus.in_eq         = eq;
        bus.in_lesser     = lt;
        bus.in_greater_eq = ge;
        if (accept) begin
            e.r1 = r1; e.r2 = r2; e.rd = rd; e.wb = wb; e.tk = tk;
            exp_q.push_back(e);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 96'(bus.out_result1), 96'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("head_entry",
                    96'({bus.out_result1, bus.out_result2, bus.out_rd, bus.out_wb_en, bus.out_taken}),
                    96'({e.r1, e.r2, e.rd, e.wb, e.tk}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_result1    = '0;
        bus.in_result2    = '0;
        bus.in_eq         = 1'b0;
        bus.in_lesser     = 1'b0;
        bus.in_greater_eq = 1'b0;
        bus.in_br_type    = 3'b000;
        bus.in_rd         = '0;
        bus.in_wb_en      = 1'b0;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b0;
        #2;
        chk("rst_out_valid", 96'(bus.out_valid), 96'(0));
        chk("rst_in_ready",  96'(bus.in_ready),  96'(1));
        chk("rst_count",     96'(bus.count),     96'(0));
        chk("rst_result1",   96'(bus.out_result1), 96'(0));
        #10 rst = 1'b0;
        step();

        // Single pass-through with one-cycle latency
        bus.out_ready = 1'b1;
        offer(32'h5, 32'h0, 5'd3, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pt_out_valid", 96'(bus.out_valid), 96'(1));
        chk("pt_count1",    96'(bus.count),     96'(1));
        step();
        chk("pt_count0",    96'(bus.count),     96'(0));
        chk("pt_valid0",    96'(bus.out_valid), 96'(0));

        // Fill with back-pressure, ignored third offer, then drain
        bus.out_ready = 1'b0;
        offer(32'h11, 32'h1, 5'd1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        offer(32'h22, 32'h2, 5'd2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fill_count",    96'(bus.count),       96'(2));
        chk("fill_in_ready", 96'(bus.in_ready),    96'(0));
        chk("fill_head",     96'(bus.out_result1), 96'h11);
        offer(32'h99, 32'h9, 5'd9, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_count",    96'(bus.count),       96'(2));
        chk("full_hold",     96'(bus.out_result1), 96'h11);
        bus.out_ready = 1'b1;
        step();
        chk("drain_count1",  96'(bus.count),    96'(1));
        chk("drain_ready",   96'(bus.in_ready), 96'(1));
        step();
        chk("drain_count0",  96'(bus.count),     96'(0));
        chk("drain_valid0",  96'(bus.out_valid), 96'(0));

        // Simultaneous push and pop across pointer wrap
        bus.out_ready = 1'b0;
        offer(32'h11, 32'h0, 5'd4, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        offer(32'h33, 32'h0, 5'd5, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pp_count",  96'(bus.count),       96'(1));
        chk("pp_head",   96'(bus.out_result1), 96'h33);
        for (int i = 0; i < 8; i++) begin
            offer(32'h40 + 32'(i), 32'(i), 5'(i + 8), i[0], 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("pp_wrap_count", 96'(bus.count), 96'(1));
        end
        step();
        chk("pp_end_count", 96'(bus.count), 96'(0));

        // Branch resolution table
        for (int i = 0; i < 9; i++) begin
            offer(32'h100 + 32'(i), 32'h0, 5'd10, 1'b0, br_v[i], eq_v[i], lt_v[i], ge_v[i], tk_v[i], 1'b1);
        end
        step();

        // Flush beats push and pop in the same cycle
        bus.out_ready = 1'b0;
        offer(32'h55, 32'h0, 5'd11, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        offer(32'h66, 32'h0, 5'd12, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fl_pre_count", 96'(bus.count), 96'(2));
        bus.flush         = 1'b1;
        bus.out_ready     = 1'b1;
        bus.in_valid      = 1'b1;
        bus.in_result1    = 32'h77;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        chk("fl_count",     96'(bus.count),     96'(0));
        chk("fl_out_valid", 96'(bus.out_valid), 96'(0));
        chk("fl_in_ready",  96'(bus.in_ready),  96'(1));
        offer(32'h44, 32'h4, 5'd13, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("fl_next_head",  96'(bus.out_result1), 96'h44);
        chk("fl_next_count", 96'(bus.count),       96'(1));
        bus.out_ready = 1'b1;
        step();
        chk("fl_drained", 96'(bus.count), 96'(0));

        // Asynchronous reset between edges while full
        bus.out_ready = 1'b0;
        offer(32'hAA, 32'hA5, 5'd7, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        offer(32'hBB, 32'hB5, 5'd6, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ar_pre_count", 96'(bus.count), 96'(2));
        #3 rst = 1'b1;
        #1;
        exp_q.delete();
        chk("ar_out_valid", 96'(bus.out_valid), 96'(0));
        chk("ar_in_ready",  96'(bus.in_ready),  96'(1));
        chk("ar_count",     96'(bus.count),     96'(0));
        chk("ar_head",
            96'({bus.out_result1, bus.out_result2, bus.out_rd, bus.out_wb_en, bus.out_taken}),
            96'(0));
        #3 rst = 1'b0;
        step();

        chk("queue_empty", 96'(exp_q.size()), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
